// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect/stall controls
// coming from the hazard unit, decode and execute, and the IF/ID outputs
// that feed the decode stage.
interface fetch_stage_if #(
  parameter int AW = 32,
  parameter int IW = 32
);
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          stall;
  logic [1:0]    jmp_sel;
  logic [AW-1:0] jmp_target;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] id_pc_plus4;
  logic [4:0]    id_opcode;
  logic [2:0]    id_aluop;
  logic          id_valid;

  // The fetch stage drives the memory address and the IF/ID register.
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  jmp_sel,
    input  jmp_target,
    input  branch_taken,
    input  branch_target,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output id_opcode,
    output id_aluop,
    output id_valid
  );

  // The surrounding pipeline: memory, hazard unit, decode and execute.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output jmp_sel,
    output jmp_target,
    output branch_taken,
    output branch_target,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  id_opcode,
    input  id_aluop,
    input  id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the interpolation
// ASIP core. Holds the PC, picks the next PC from branch / stall / jump /
// sequential sources in that priority, and registers the fetched word
// together with its PC for the decode stage.
module fetch_stage #(
  parameter int            AW        = 32,
  parameter int            IW        = 32,
  parameter logic [AW-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [IW-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam logic [AW-1:0] PC_INC = AW'(3'd4);

  logic [AW-1:0] pc_r;
  logic [IW-1:0] id_instr_r;
  logic [AW-1:0] id_pc_r;
  logic          id_valid_r;

  logic [AW-1:0] pc_nxt_s;
  logic [IW-1:0] id_instr_nxt_s;
  logic [AW-1:0] id_pc_nxt_s;
  logic          id_valid_nxt_s;
  logic          jump_s;
  logic [AW-1:0] jmp_aligned_s;
  logic [AW-1:0] br_aligned_s;
  logic [AW-1:0] pc_seq_s;

  // Targets are word aligned; low two bits are dropped, and the
  // sequential increment simply wraps modulo 2^AW.
  assign jmp_aligned_s = {bus.jmp_target[AW-1:2], 2'b00};
  assign br_aligned_s  = {bus.branch_target[AW-1:2], 2'b00};
  assign pc_seq_s      = pc_r + PC_INC;

  // Decode jump select; the reserved encoding behaves as sequential.
  always_comb begin
    jump_s = 1'b0;
    case (bus.jmp_sel)
      2'b01:   jump_s = 1'b1;
      2'b10:   jump_s = 1'b1;
      default: jump_s = 1'b0;
    endcase
  end

  // Next-PC / IF/ID selection. A branch is older than any jump sitting in
  // ID and also overrides a stall; a stall freezes everything so the jump
  // in ID re-asserts afterwards. Flushed slots record the squashed PC.
  always_comb begin
    pc_nxt_s       = pc_r;
    id_instr_nxt_s = id_instr_r;
    id_pc_nxt_s    = id_pc_r;
    id_valid_nxt_s = id_valid_r;
    if (bus.branch_taken) begin
      pc_nxt_s       = br_aligned_s;
      id_instr_nxt_s = NOP_INSTR;
      id_pc_nxt_s    = pc_r;
      id_valid_nxt_s = 1'b0;
    end else if (bus.stall) begin
      pc_nxt_s       = pc_r;
      id_instr_nxt_s = id_instr_r;
      id_pc_nxt_s    = id_pc_r;
      id_valid_nxt_s = id_valid_r;
    end else if (jump_s) begin
      pc_nxt_s       = jmp_aligned_s;
      id_instr_nxt_s = NOP_INSTR;
      id_pc_nxt_s    = pc_r;
      id_valid_nxt_s = 1'b0;
    end else begin
      pc_nxt_s       = pc_seq_s;
      id_instr_nxt_s = bus.imem_rdata;
      id_pc_nxt_s    = pc_r;
      id_valid_nxt_s = 1'b1;
    end
  end

  // PC and IF/ID register; reset wins over any stall or redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      id_instr_r <= NOP_INSTR;
      id_pc_r    <= RESET_PC;
      id_valid_r <= 1'b0;
    end else begin
      pc_r       <= pc_nxt_s;
      id_instr_r <= id_instr_nxt_s;
      id_pc_r    <= id_pc_nxt_s;
      id_valid_r <= id_valid_nxt_s;
    end
  end

  // Outputs are the registers or fixed slices of them, so they only move
  // on the clock edge.
  assign bus.imem_addr   = pc_r;
  assign bus.id_instr    = id_instr_r;
  assign bus.id_pc       = id_pc_r;
  assign bus.id_pc_plus4 = id_pc_r + PC_INC;
  assign bus.id_opcode   = id_instr_r[31:27];
  assign bus.id_aluop    = id_instr_r[26:24];
  assign bus.id_valid    = id_valid_r;

endmodule
